gerador_borda: RTL and testbench

Edge generator: drives a single-bit line `sinal` with clean, rate-limited transitions on request. It is the transmit-side counterpart of the edge detector: a command stream in, a waveform out. It also reports each transition it creates on `borda` using the detector's 2-bit encoding (00 none, 01 rising, 10 falling). Its purpose is to stimulate edge-sensitive logic, including the detector, with a deterministic minimum dwell time between edges.

---
 rtl/gerador_borda.sv | 107 ++++++++++
 tb/tb_gerador_borda.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/gerador_borda.sv
// Edge generator: turns a command stream into a clean single-bit waveform with a
// guaranteed dwell after every transition, flagging each edge it creates on borda.
module gerador_borda #(
   parameter int HOLD_CYCLES  = 4,
   parameter int PULSE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   output logic       sinal,
   output logic [1:0] borda,
   output logic       busy
);

   localparam int MAX_CYCLES = (HOLD_CYCLES > PULSE_CYCLES) ? HOLD_CYCLES : PULSE_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);

   localparam logic [1:0] EDGE_NONE = 2'b00;
   localparam logic [1:0] EDGE_RISE = 2'b01;
   localparam logic [1:0] EDGE_FALL = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      PULSE,
      HOLD
   } state_t;

   state_t          state;
   logic   [CW-1:0] count;
   logic            accept;

   assign cmd_ready = !rst && (state == IDLE);
   assign busy      = (state != IDLE);
   assign accept    = cmd_valid && cmd_ready;

   // Every transition, including the pulse restore, enters HOLD so the line always
   // dwells before the next command; borda defaults to none and is set only on a change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         sinal <= 1'b0;
         borda <= EDGE_NONE;
      end else begin
         borda <= EDGE_NONE;
         case (state)
            IDLE: begin
               if (accept) begin
                  case (cmd)
                     2'b01: begin
                        if (!sinal) begin
                           sinal <= 1'b1;
                           borda <= EDGE_RISE;
                           state <= HOLD;
                           count <= HOLD_LOAD;
                        end
                     end
                     2'b10: begin
                        if (sinal) begin
                           sinal <= 1'b0;
                           borda <= EDGE_FALL;
                           state <= HOLD;
                           count <= HOLD_LOAD;
                        end
                     end
                     2'b11: begin
                        sinal <= ~sinal;
                        borda <= sinal ? EDGE_FALL : EDGE_RISE;
                        state <= PULSE;
                        count <= PULSE_LOAD;
                     end
                     default: begin
                     end
                  endcase
               end
            end
            PULSE: begin
               if (count == '0) begin
                  sinal <= ~sinal;
                  borda <= sinal ? EDGE_FALL : EDGE_RISE;
                  state <= HOLD;
                  count <= HOLD_LOAD;
               end else begin
                  count <= count - CW'(1);
               end
            end
            HOLD: begin
               if (count == '0) begin
                  state <= IDLE;
               end else begin
                  count <= count - CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               count <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gerador_borda.sv
// Directed bench for gerador_borda (HOLD_CYCLES=4, PULSE_CYCLES=2): a per-cycle vector
// table of inputs and expected outputs, plus a hand sequence for reset during a pulse.
module tb_gerador_borda;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd;
   logic       sinal;
   logic [1:0] borda;
   logic       busy;

   int vectorCount = 0;
   int missCount   = 0;

   typedef struct {
      logic       rst;
      logic       valid;
      logic [1:0] cmd;
      logic       expSinal;
      logic [1:0] expBorda;
      logic       expBusy;
      logic       expReady;
   } vec_t;

   localparam int NVEC = 36;
   vec_t vecs[NVEC];

   gerador_borda #(
      .HOLD_CYCLES (4),
      .PULSE_CYCLES(2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd      (cmd),
      .sinal    (sinal),
      .borda    (borda),
      .busy     (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic setVec(input int idx, input logic r, input logic v, input logic [1:0] c,
                         input logic s, input logic [1:0] b, input logic bz, input logic rdy);
      vecs[idx] = '{r, v, c, s, b, bz, rdy};
   endtask

   task automatic applyStimulus(input logic r, input logic v, input logic [1:0] c);
      @(negedge clk);
      rst       = r;
      cmd_valid = v;
      cmd       = c;
   endtask

   task automatic checkOutput(input string name, input logic s, input logic [1:0] b,
                              input logic bz, input logic rdy);
      vectorCount++;
      if (sinal !== s) begin
         missCount++;
         $display("[TB] FAIL %s sinal: got %b expected %b", name, sinal, s);
      end
      if (borda !== b) begin
         missCount++;
         $display("[TB] FAIL %s borda: got %b expected %b", name, borda, b);
      end
      if (busy !== bz) begin
         missCount++;
         $display("[TB] FAIL %s busy: got %b expected %b", name, busy, bz);
      end
      if (cmd_ready !== rdy) begin
         missCount++;
         $display("[TB] FAIL %s cmd_ready: got %b expected %b", name, cmd_ready, rdy);
      end
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd       = 2'b00;

      // Reset for 3 cycles, release, then redundant 10 and 00 while low.
      setVec(0,  1, 0, 2'b00, 0, 2'b00, 0, 0);
      setVec(1,  1, 0, 2'b00, 0, 2'b00, 0, 0);
      setVec(2,  1, 0, 2'b00, 0, 2'b00, 0, 0);
      setVec(3,  0, 0, 2'b00, 0, 2'b00, 0, 1);
      setVec(4,  0, 1, 2'b10, 0, 2'b00, 0, 1);
      setVec(5,  0, 1, 2'b00, 0, 2'b00, 0, 1);
      // Set high at E0, then a 10 held valid: ignored through the dwell, taken once ready.
      setVec(6,  0, 1, 2'b01, 1, 2'b01, 1, 0);
      setVec(7,  0, 1, 2'b10, 1, 2'b00, 1, 0);
      setVec(8,  0, 1, 2'b10, 1, 2'b00, 1, 0);
      setVec(9,  0, 1, 2'b10, 1, 2'b00, 1, 0);
      setVec(10, 0, 1, 2'b10, 1, 2'b00, 0, 1);
      setVec(11, 0, 1, 2'b10, 0, 2'b10, 1, 0);
      setVec(12, 0, 0, 2'b00, 0, 2'b00, 1, 0);
      setVec(13, 0, 0, 2'b00, 0, 2'b00, 1, 0);
      setVec(14, 0, 0, 2'b00, 0, 2'b00, 1, 0);
      setVec(15, 0, 0, 2'b00, 0, 2'b00, 0, 1);
      // Pulse from low: 01 then 10 two cycles apart, ready low for 6 cycles.
      setVec(16, 0, 1, 2'b11, 1, 2'b01, 1, 0);
      setVec(17, 0, 1, 2'b10, 1, 2'b00, 1, 0);
      setVec(18, 0, 0, 2'b00, 0, 2'b10, 1, 0);
      setVec(19, 0, 0, 2'b00, 0, 2'b00, 1, 0);
      setVec(20, 0, 0, 2'b00, 0, 2'b00, 1, 0);
      setVec(21, 0, 0, 2'b00, 0, 2'b00, 1, 0);
      setVec(22, 0, 0, 2'b00, 0, 2'b00, 0, 1);
      // Raise the line, redundant 01, then pulse from high: 10 then 01.
      setVec(23, 0, 1, 2'b01, 1, 2'b01, 1, 0);
      setVec(24, 0, 0, 2'b00, 1, 2'b00, 1, 0);
      setVec(25, 0, 0, 2'b00, 1, 2'b00, 1, 0);
      setVec(26, 0, 0, 2'b00, 1, 2'b00, 1, 0);
      setVec(27, 0, 0, 2'b00, 1, 2'b00, 0, 1);
      setVec(28, 0, 1, 2'b01, 1, 2'b00, 0, 1);
      setVec(29, 0, 1, 2'b11, 0, 2'b10, 1, 0);
      setVec(30, 0, 0, 2'b00, 0, 2'b00, 1, 0);
      setVec(31, 0, 0, 2'b00, 1, 2'b01, 1, 0);
      setVec(32, 0, 0, 2'b00, 1, 2'b00, 1, 0);
      setVec(33, 0, 0, 2'b00, 1, 2'b00, 1, 0);
      setVec(34, 0, 0, 2'b00, 1, 2'b00, 1, 0);
      setVec(35, 0, 0, 2'b00, 1, 2'b00, 0, 1);

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].cmd);
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d", i), vecs[i].expSinal, vecs[i].expBorda,
                     vecs[i].expBusy, vecs[i].expReady);
      end

      // Reset mid-pulse: bring the line low first, then pulse and reset one cycle later.
      applyStimulus(1'b1, 1'b0, 2'b00);
      @(posedge clk);
      #1;
      checkOutput("pre_reset", 1'b0, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 2'b11);
      @(posedge clk);
      #1;
      checkOutput("mid_accept", 1'b1, 2'b01, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 2'b00);
      @(posedge clk);
      #1;
      checkOutput("mid_pulse", 1'b1, 2'b00, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      checkOutput("async_reset", 1'b0, 2'b00, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("reset_held", 1'b0, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 2'b00);
      #1;
      checkOutput("reset_release", 1'b0, 2'b00, 1'b0, 1'b1);
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("no_restore%0d", k), 1'b0, 2'b00, 1'b0, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

   initial begin
      #20000;
      missCount++;
      $display("[TB] FAIL timeout: got no end of test, expected completion before 20000");
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
